// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the issue stage.
//   NUM_REGS / REG_W : architectural register file shape
//   REG_ZERO         : hard-wired zero register index
//   issue_state_t    : issue controller FSM states
//   reg_onehot()     : register index to scoreboard bit mask; x0 never maps to a bit
package pipeline_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_W    = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } issue_state_t;

    // Writes to x0 are architectural no-ops, so they never produce a mask bit.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t r, input logic en);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (en && (r != REG_ZERO)) begin
            mask[r] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode / execute / writeback handshake bundle around the issue controller.
//   master : pipeline side (drives decode fields, ex_ready, writeback, redirect)
//   slave  : issue_ctrl side (drives dec_stall, issue_valid, flush, pending_cnt)
interface issue_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 4
) ();

    localparam int unsigned CntW = $clog2(MAX_PENDING + 1);

    // Decode
    logic     dec_valid;
    reg_idx_t dec_rs1;
    reg_idx_t dec_rs2;
    reg_idx_t dec_rd;
    logic     dec_uses_rs1;
    logic     dec_uses_rs2;
    logic     dec_writes_rd;
    logic     dec_stall;
    logic     issue_valid;

    // Execute / writeback
    logic     ex_ready;
    logic     wb_valid;
    reg_idx_t wb_rd;
    logic     redirect_valid;

    // Fetch / debug
    logic            flush;
    logic [CntW-1:0] pending_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
        output dec_uses_rs1, dec_uses_rs2, dec_writes_rd,
        output ex_ready, wb_valid, wb_rd, redirect_valid,
        input  dec_stall, issue_valid, flush, pending_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
        input  dec_uses_rs1, dec_uses_rs2, dec_writes_rd,
        input  ex_ready, wb_valid, wb_rd, redirect_valid,
        output dec_stall, issue_valid, flush, pending_cnt
    );

endinterface

// File: rtl/scoreboard.sv
// Register scoreboard: one pending bit per architectural register plus a
// running count of outstanding writes.
//   clk, reset          : clock, asynchronous active-low reset
//   set_en_i/set_rd_i   : mark a destination as outstanding (issue)
//   clr_en_i/clr_rd_i   : release a destination (writeback)
//   rs1_i/rs2_i/rd_i    : lookup indices; *_hit_o report pending bits
//   full_o              : count has reached MAX_PENDING
//   pending_cnt_o       : outstanding write count
module scoreboard
    import pipeline_pkg::*;
#(
    parameter int unsigned  MAX_PENDING = 4,
    localparam int unsigned CntW        = $clog2(MAX_PENDING + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en_i,
    input  reg_idx_t        set_rd_i,
    input  logic            clr_en_i,
    input  reg_idx_t        clr_rd_i,
    input  reg_idx_t        rs1_i,
    input  reg_idx_t        rs2_i,
    input  reg_idx_t        rd_i,
    output logic            rs1_hit_o,
    output logic            rs2_hit_o,
    output logic            rd_hit_o,
    output logic            full_o,
    output logic [CntW-1:0] pending_cnt_o
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask, pending_cleared;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                set_eff, clr_eff;

    always_comb begin
        set_mask        = reg_onehot(set_rd_i, set_en_i);
        // A writeback for a register that is not pending is dropped here so the
        // count cannot underflow or drift from the bit vector.
        clr_mask        = reg_onehot(clr_rd_i, clr_en_i) & pending_q;
        clr_eff         = |clr_mask;
        pending_cleared = pending_q & ~clr_mask;
        // Count a set only if it really turns a bit on after this cycle's clear.
        set_eff         = |(set_mask & ~pending_cleared);
        pending_d       = pending_cleared | set_mask;
        cnt_d           = cnt_q + CntW'(set_eff) - CntW'(clr_eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        rs1_hit_o     = pending_q[rs1_i];
        rs2_hit_o     = pending_q[rs2_i];
        rd_hit_o      = (rd_i != REG_ZERO) && pending_q[rd_i];
        full_o        = (cnt_q == CntW'(MAX_PENDING));
        pending_cnt_o = cnt_q;
    end

    a_cnt_is_popcount : assert property (@(posedge clk) disable iff (!reset)
        cnt_q == CntW'($countones(pending_q)));

    a_x0_never_pending : assert property (@(posedge clk) disable iff (!reset)
        !pending_q[0]);

    a_wb_to_pending : assert property (@(posedge clk) disable iff (!reset)
        (clr_en_i && (clr_rd_i != REG_ZERO)) |-> pending_q[clr_rd_i]);

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        (set_eff && !clr_eff) |-> !full_o);

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller between decode and execute. Tracks outstanding register
// writes, stalls decode on RAW/WAW hazards, execute back-pressure or a full
// scoreboard, and drives a fixed-length flush after each execute redirect.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : issue_ctrl_if.slave (decode, execute, writeback, flush, count)
module issue_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MAX_PENDING  = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    issue_ctrl_if.slave  bus
);

    localparam int unsigned CntW = $clog2(MAX_PENDING + 1);
    localparam int unsigned FcW  = $clog2(FLUSH_CYCLES + 1);

    issue_state_t   state_q, state_d;
    logic [FcW-1:0] fcnt_q, fcnt_d;

    logic            rs1_hit, rs2_hit, rd_hit, sb_full;
    logic [CntW-1:0] sb_cnt;
    logic            hazard;
    logic            dec_stall, issue_valid, flush;
    logic            set_en, clr_en;

    scoreboard #(
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .set_en_i      (set_en),
        .set_rd_i      (bus.dec_rd),
        .clr_en_i      (clr_en),
        .clr_rd_i      (bus.wb_rd),
        .rs1_i         (bus.dec_rs1),
        .rs2_i         (bus.dec_rs2),
        .rd_i          (bus.dec_rd),
        .rs1_hit_o     (rs1_hit),
        .rs2_hit_o     (rs2_hit),
        .rd_hit_o      (rd_hit),
        .full_o        (sb_full),
        .pending_cnt_o (sb_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state: fcnt_q holds the flush cycles still to go, including the current one.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            RUN: begin
                if (bus.redirect_valid) begin
                    state_d = FLUSH;
                    fcnt_d  = FcW'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (bus.redirect_valid) begin
                    fcnt_d = FcW'(FLUSH_CYCLES);
                end else begin
                    fcnt_d = fcnt_q - FcW'(1);
                    if (fcnt_q == FcW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    // Outputs and scoreboard controls
    always_comb begin
        // rd_hit already excludes x0; no writeback bypass, so a hit always stalls.
        hazard = (bus.dec_uses_rs1 && rs1_hit) ||
                 (bus.dec_uses_rs2 && rs2_hit) ||
                 (bus.dec_writes_rd && rd_hit);
        // Deliberately independent of dec_valid to keep the decode loop acyclic.
        dec_stall = hazard || !bus.ex_ready || (sb_full && bus.dec_writes_rd) ||
                    (state_q != RUN);
        // Gating with reset keeps issue_valid low while reset is held, without a clock.
        issue_valid = reset && bus.dec_valid && (state_q == RUN) && !bus.redirect_valid;
        flush       = (state_q == FLUSH);
        set_en      = issue_valid && bus.dec_writes_rd && (bus.dec_rd != REG_ZERO);
        clr_en      = bus.wb_valid && (bus.wb_rd != REG_ZERO);
    end

    assign bus.dec_stall   = dec_stall;
    assign bus.issue_valid = issue_valid;
    assign bus.flush       = flush;
    assign bus.pending_cnt = sb_cnt;

    a_flush_cnt_live : assert property (@(posedge clk) disable iff (!reset)
        (state_q == FLUSH) |-> (fcnt_q != '0));

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
    import pipeline_pkg::*;

    localparam int unsigned MaxPend  = 4;
    localparam int unsigned FlushCyc = 2;
    localparam int unsigned CntW     = $clog2(MaxPend + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    issue_ctrl_if #(.MAX_PENDING(MaxPend)) bus ();

    issue_ctrl #(
        .MAX_PENDING  (MaxPend),
        .FLUSH_CYCLES (FlushCyc)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: set of outstanding destinations and flush cycles left.
    int pend_q[$];
    int flush_left;

    logic            s_stall, s_issue, s_flush;
    logic [CntW-1:0] s_cnt;

    typedef struct {
        bit ex_ready;
        bit dec_valid;
        bit u1;
        int rs1;
        bit u2;
        int rs2;
        bit w;
        int rd;
        bit e_stall;
        bit e_issue;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_pend(input int r);
        foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        bit hz;
        hz = (bus.dec_uses_rs1 && in_pend(int'(bus.dec_rs1))) ||
             (bus.dec_uses_rs2 && in_pend(int'(bus.dec_rs2))) ||
             (bus.dec_writes_rd && bus.dec_rd != 0 && in_pend(int'(bus.dec_rd)));
        return hz || !bus.ex_ready || (pend_q.size() == MaxPend && bus.dec_writes_rd) ||
               (flush_left != 0);
    endfunction

    function automatic bit model_issue();
        return bus.dec_valid && (flush_left == 0) && !bus.redirect_valid;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        flush_left = 0;
    endtask

    task automatic model_update(input bit iss);
        if (bus.wb_valid && bus.wb_rd != 0) begin
            for (int i = 0; i < pend_q.size(); i++) begin
                if (pend_q[i] == int'(bus.wb_rd)) begin
                    pend_q.delete(i);
                    break;
                end
            end
        end
        if (iss && bus.dec_writes_rd && bus.dec_rd != 0) pend_q.push_back(int'(bus.dec_rd));
        if (bus.redirect_valid) flush_left = FlushCyc;
        else if (flush_left > 0) flush_left--;
    endtask

    // One cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        bit iss;
        @(negedge clk);
        s_stall = bus.dec_stall;
        s_issue = bus.issue_valid;
        s_flush = bus.flush;
        s_cnt   = bus.pending_cnt;
        check("model_stall", s_stall, model_stall());
        check("model_issue", s_issue, model_issue());
        check("model_flush", s_flush, flush_left != 0);
        check("model_cnt", s_cnt, pend_q.size());
        iss = model_issue();
        @(posedge clk);
        model_update(iss);
        #1;
    endtask

    task automatic set_idle();
        bus.dec_valid      = 1'b0;
        bus.dec_rs1        = '0;
        bus.dec_rs2        = '0;
        bus.dec_rd         = '0;
        bus.dec_uses_rs1   = 1'b0;
        bus.dec_uses_rs2   = 1'b0;
        bus.dec_writes_rd  = 1'b0;
        bus.ex_ready       = 1'b1;
        bus.wb_valid       = 1'b0;
        bus.wb_rd          = '0;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic drive_dec(input bit v, input bit u1, input int r1, input bit u2,
                             input int r2, input bit w, input int rd);
        bus.dec_valid     = v;
        bus.dec_uses_rs1  = u1;
        bus.dec_rs1       = 5'(r1);
        bus.dec_uses_rs2  = u2;
        bus.dec_rs2       = 5'(r2);
        bus.dec_writes_rd = w;
        bus.dec_rd        = 5'(rd);
    endtask

    task automatic wb(input bit v, input int r);
        bus.wb_valid = v;
        bus.wb_rd    = 5'(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int drain[4];
        // Pending set while the table runs: {1,3,4,6}, scoreboard full.
        tbl[0] = '{1, 0, 1, 3, 0, 0, 0, 0, 1, 0};
        tbl[1] = '{1, 0, 0, 0, 1, 6, 0, 0, 1, 0};
        tbl[2] = '{1, 0, 0, 0, 0, 0, 1, 2, 1, 0};
        tbl[3] = '{1, 1, 1, 2, 1, 7, 0, 0, 0, 1};
        tbl[4] = '{1, 0, 0, 3, 0, 4, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 1, 2, 0, 0, 0, 0, 1, 0};
        tbl[6] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[7] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        tbl[8] = '{1, 0, 0, 0, 0, 0, 1, 4, 1, 0};
        tbl[9] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        drain  = '{1, 3, 4, 6};

        // Reset, idle
        set_idle();
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check("reset_stall", s_stall, 0);
        check("reset_flush", s_flush, 0);
        check("reset_cnt", s_cnt, 0);
        check("reset_issue", s_issue, 0);

        // RAW on x5, released by writeback in cycle N, issue in N+1
        drive_dec(1, 0, 0, 0, 0, 1, 5);
        tick();
        check("raw_writer_issue", s_issue, 1);
        drive_dec(0, 1, 5, 0, 0, 0, 0);
        tick();
        check("raw_stall_1", s_stall, 1);
        tick();
        check("raw_stall_2", s_stall, 1);
        wb(1, 5);
        tick();
        check("raw_stall_wb_cycle", s_stall, 1);
        wb(0, 0);
        drive_dec(1, 1, 5, 0, 0, 0, 0);
        tick();
        check("raw_release_stall", s_stall, 0);
        check("raw_release_issue", s_issue, 1);
        set_idle();

        // Full scoreboard
        for (int i = 1; i <= 4; i++) begin
            drive_dec(1, 0, 0, 0, 0, 1, i);
            tick();
        end
        drive_dec(0, 0, 0, 0, 0, 1, 6);
        tick();
        check("full_cnt", s_cnt, 4);
        check("full_writer_stall", s_stall, 1);
        drive_dec(1, 1, 7, 0, 0, 0, 0);
        tick();
        check("full_reader_stall", s_stall, 0);
        check("full_reader_issue", s_issue, 1);
        drive_dec(0, 0, 0, 0, 0, 1, 6);
        wb(1, 2);
        tick();
        check("full_wb_cycle_stall", s_stall, 1);
        wb(0, 0);
        drive_dec(1, 0, 0, 0, 0, 1, 6);
        tick();
        check("full_x6_stall", s_stall, 0);
        check("full_x6_issue", s_issue, 1);
        set_idle();
        tick();
        check("full_again_cnt", s_cnt, 4);

        // Single-cycle probes against the full {1,3,4,6} scoreboard
        foreach (tbl[i]) begin
            bus.ex_ready = tbl[i].ex_ready;
            drive_dec(tbl[i].dec_valid, tbl[i].u1, tbl[i].rs1, tbl[i].u2, tbl[i].rs2,
                      tbl[i].w, tbl[i].rd);
            tick();
            check($sformatf("tbl%0d_stall", i), s_stall, tbl[i].e_stall);
            check($sformatf("tbl%0d_issue", i), s_issue, tbl[i].e_issue);
        end
        set_idle();
        foreach (drain[i]) begin
            wb(1, drain[i]);
            tick();
        end
        wb(0, 0);
        tick();
        check("drained_cnt", s_cnt, 0);

        // x0 handling
        drive_dec(1, 0, 0, 0, 0, 1, 0);
        tick();
        check("x0_writer_issue", s_issue, 1);
        drive_dec(1, 0, 0, 0, 0, 1, 9);
        tick();
        check("x0_cnt_unchanged", s_cnt, 0);
        drive_dec(0, 1, 0, 1, 0, 0, 0);
        wb(1, 0);
        tick();
        check("x0_reader_stall", s_stall, 0);
        check("x9_cnt", s_cnt, 1);
        wb(1, 9);
        tick();
        check("x0_wb_cnt_unchanged", s_cnt, 1);
        set_idle();
        tick();
        check("x9_released_cnt", s_cnt, 0);

        // Flush after a redirect with decode valid in the same cycle
        drive_dec(1, 0, 0, 0, 0, 0, 0);
        bus.redirect_valid = 1'b1;
        tick();
        check("redirect_drop_issue", s_issue, 0);
        set_idle();
        tick();
        check("flush_n1", s_flush, 1);
        check("flush_n1_stall", s_stall, 1);
        tick();
        check("flush_n2", s_flush, 1);
        tick();
        check("flush_n3_run", s_flush, 0);
        check("flush_n3_stall", s_stall, 0);
        bus.redirect_valid = 1'b1;
        tick();
        tick();
        check("flush2_n1", s_flush, 1);
        bus.redirect_valid = 1'b0;
        tick();
        check("flush2_n2", s_flush, 1);
        tick();
        check("flush2_n3", s_flush, 1);
        tick();
        check("flush2_n4_run", s_flush, 0);

        // Asynchronous reset mid-flush with three writes outstanding
        for (int i = 10; i <= 12; i++) begin
            drive_dec(1, 0, 0, 0, 0, 1, i);
            tick();
        end
        set_idle();
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.dec_valid      = 1'b1;
        #1;
        check("pre_reset_flush", bus.flush, 1);
        check("pre_reset_cnt", bus.pending_cnt, 3);
        #1 reset = 1'b0;
        #1;
        check("async_flush", bus.flush, 0);
        check("async_cnt", bus.pending_cnt, 0);
        check("async_issue", bus.issue_valid, 0);
        model_reset();
        set_idle();
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check("post_reset_stall", s_stall, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            bus.ex_ready       = ($urandom_range(0, 7) != 0);
            bus.dec_uses_rs1   = 1'($urandom_range(0, 1));
            bus.dec_uses_rs2   = 1'($urandom_range(0, 1));
            bus.dec_writes_rd  = ($urandom_range(0, 3) != 0);
            bus.dec_rs1        = 5'($urandom_range(0, 7));
            bus.dec_rs2        = 5'($urandom_range(0, 7));
            bus.dec_rd         = 5'($urandom_range(0, 7));
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb(1, pend_q[$urandom_range(0, pend_q.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                wb(1, 0);
            end else begin
                wb(0, 0);
            end
            bus.dec_valid = 1'b0;
            bus.dec_valid = ($urandom_range(0, 3) != 0) && !model_stall();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
